mini_calc_arbiter: RTL and testbench

Round-robin scheduler that shares one MiniCalc datapath between two requesters. Each requester has a valid/ready request channel (instruction plus operands) and a valid/ready response channel (two result words). The block latches the granted request and drives it stable into the calculator for CALC_LATENCY cycles. It then captures OutputA/OutputB and returns them to the same requester.

---
 rtl/mini_calc_arbiter_if.sv | 61 ++++++
 rtl/mini_calc_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_mini_calc_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mini_calc_arbiter_if.sv
// ---------------------------------------------------------------------------
// mini_calc_arbiter_if
// Bundles the two requester channels and the MiniCalc connection of the
// round-robin calculator arbiter.
//   Req0*/Req1*  : request channel (Valid/Ready, Instr, A, B) per requester
//   Rsp0*/Rsp1*  : response channel (Valid/Ready, A, B) per requester
//   Calc*        : instruction/operands to MiniCalc and its two result words
//   Busy         : arbiter is not idle
// Modports:
//   slave  : the arbiter itself
//   master : requesters plus the calculator (the environment around it)
// ---------------------------------------------------------------------------
interface mini_calc_arbiter_if #(
    parameter int INPUT_BIT_WIDTH = 8,
    parameter int INSTR_BIT_WIDTH = 4
);
    logic                       Req0Valid;
    logic                       Req0Ready;
    logic [INSTR_BIT_WIDTH-1:0] Req0Instr;
    logic [INPUT_BIT_WIDTH-1:0] Req0A;
    logic [INPUT_BIT_WIDTH-1:0] Req0B;
    logic                       Rsp0Valid;
    logic                       Rsp0Ready;
    logic [INPUT_BIT_WIDTH-1:0] Rsp0A;
    logic [INPUT_BIT_WIDTH-1:0] Rsp0B;

    logic                       Req1Valid;
    logic                       Req1Ready;
    logic [INSTR_BIT_WIDTH-1:0] Req1Instr;
    logic [INPUT_BIT_WIDTH-1:0] Req1A;
    logic [INPUT_BIT_WIDTH-1:0] Req1B;
    logic                       Rsp1Valid;
    logic                       Rsp1Ready;
    logic [INPUT_BIT_WIDTH-1:0] Rsp1A;
    logic [INPUT_BIT_WIDTH-1:0] Rsp1B;

    logic [INSTR_BIT_WIDTH-1:0] CalcInstruction;
    logic [INPUT_BIT_WIDTH-1:0] CalcInputA;
    logic [INPUT_BIT_WIDTH-1:0] CalcInputB;
    logic [INPUT_BIT_WIDTH-1:0] CalcOutputA;
    logic [INPUT_BIT_WIDTH-1:0] CalcOutputB;
    logic                       Busy;

    modport slave (
        input  Req0Valid, Req0Instr, Req0A, Req0B, Rsp0Ready,
        input  Req1Valid, Req1Instr, Req1A, Req1B, Rsp1Ready,
        input  CalcOutputA, CalcOutputB,
        output Req0Ready, Rsp0Valid, Rsp0A, Rsp0B,
        output Req1Ready, Rsp1Valid, Rsp1A, Rsp1B,
        output CalcInstruction, CalcInputA, CalcInputB, Busy
    );

    modport master (
        output Req0Valid, Req0Instr, Req0A, Req0B, Rsp0Ready,
        output Req1Valid, Req1Instr, Req1A, Req1B, Rsp1Ready,
        output CalcOutputA, CalcOutputB,
        input  Req0Ready, Rsp0Valid, Rsp0A, Rsp0B,
        input  Req1Ready, Rsp1Valid, Rsp1A, Rsp1B,
        input  CalcInstruction, CalcInputA, CalcInputB, Busy
    );
endinterface

// File: rtl/mini_calc_arbiter.sv
// ---------------------------------------------------------------------------
// mini_calc_arbiter
// Round-robin scheduler sharing one MiniCalc datapath between two requesters.
// A granted request is latched and driven stable into the calculator for
// CALC_LATENCY cycles; the result pair is then captured and returned to the
// requester that issued it. One transaction in flight at a time.
// Ports:
//   Clk   : clock, all state on rising edge
//   Reset : synchronous, active-high reset
//   bus   : request/response channels, MiniCalc connection, Busy
//           (see mini_calc_arbiter_if)
// ---------------------------------------------------------------------------
module mini_calc_arbiter #(
    parameter int                         INPUT_BIT_WIDTH = 8,
    parameter int                         INSTR_BIT_WIDTH = 4,
    parameter logic [INSTR_BIT_WIDTH-1:0] CODE_INSTR_NOP  = 4'b1111,
    parameter int                         CALC_LATENCY    = 2
) (
    input  logic                   Clk,
    input  logic                   Reset,
    mini_calc_arbiter_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXEC    = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    // Count starts at LATENCY-1 so capture lands at the end of cycle T+LATENCY.
    localparam logic [7:0] COUNT_INIT = 8'(CALC_LATENCY - 1);
    localparam logic [INPUT_BIT_WIDTH-1:0] DATA_ZERO = {INPUT_BIT_WIDTH{1'b0}};

    state_t                     state_r,      state_s;
    logic                       owner_r,      owner_s;
    logic                       last_grant_r, last_grant_s;
    logic [7:0]                 count_r,      count_s;
    logic [INSTR_BIT_WIDTH-1:0] instr_r,      instr_s;
    logic [INPUT_BIT_WIDTH-1:0] op_a_r,       op_a_s;
    logic [INPUT_BIT_WIDTH-1:0] op_b_r,       op_b_s;
    logic [INPUT_BIT_WIDTH-1:0] res_a_r,      res_a_s;
    logic [INPUT_BIT_WIDTH-1:0] res_b_r,      res_b_s;
    logic                       rsp0_valid_r, rsp0_valid_s;
    logic                       rsp1_valid_r, rsp1_valid_s;
    logic                       busy_r,       busy_s;

    logic                       grant_s;
    logic                       req0_ready_s;
    logic                       req1_ready_s;
    logic                       owner_rsp_ready_s;

    // Round-robin pick: a tie goes to whoever was not granted last time.
    always_comb begin
        if (bus.Req0Valid && bus.Req1Valid) begin
            grant_s = ~last_grant_r;
        end else if (bus.Req1Valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Ready is gated by Reset so that a request arriving during reset is never accepted.
    assign req0_ready_s = !Reset && (state_r == ST_IDLE) && bus.Req0Valid && !grant_s;
    assign req1_ready_s = !Reset && (state_r == ST_IDLE) && bus.Req1Valid &&  grant_s;

    // Select the response-ready of the requester that owns the transaction.
    always_comb begin
        if (owner_r) begin
            owner_rsp_ready_s = bus.Rsp1Ready;
        end else begin
            owner_rsp_ready_s = bus.Rsp0Ready;
        end
    end

    // Next-state and next-register logic of the transaction FSM.
    always_comb begin
        state_s      = state_r;
        owner_s      = owner_r;
        last_grant_s = last_grant_r;
        count_s      = count_r;
        instr_s      = instr_r;
        op_a_s       = op_a_r;
        op_b_s       = op_b_r;
        res_a_s      = res_a_r;
        res_b_s      = res_b_r;
        rsp0_valid_s = rsp0_valid_r;
        rsp1_valid_s = rsp1_valid_r;
        busy_s       = busy_r;
        case (state_r)
            ST_IDLE: begin
                if (req0_ready_s || req1_ready_s) begin
                    state_s      = ST_EXEC;
                    owner_s      = grant_s;
                    last_grant_s = grant_s;
                    count_s      = COUNT_INIT;
                    busy_s       = 1'b1;
                    if (grant_s) begin
                        instr_s = bus.Req1Instr;
                        op_a_s  = bus.Req1A;
                        op_b_s  = bus.Req1B;
                    end else begin
                        instr_s = bus.Req0Instr;
                        op_a_s  = bus.Req0A;
                        op_b_s  = bus.Req0B;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (count_r != 8'd0) begin
                    count_s = count_r - 8'd1;
                end else begin
                    res_a_s = bus.CalcOutputA;
                    res_b_s = bus.CalcOutputB;
                    state_s = ST_RESPOND;
                    if (owner_r) begin
                        rsp1_valid_s = 1'b1;
                    end else begin
                        rsp0_valid_s = 1'b1;
                    end
                end
            end
            ST_RESPOND: begin
                if (owner_rsp_ready_s) begin
                    // Back to idle: calculator returns to NOP with zero operands.
                    state_s      = ST_IDLE;
                    rsp0_valid_s = 1'b0;
                    rsp1_valid_s = 1'b0;
                    busy_s       = 1'b0;
                    instr_s      = CODE_INSTR_NOP;
                    op_a_s       = DATA_ZERO;
                    op_b_s       = DATA_ZERO;
                end else begin
                    state_s = ST_RESPOND;
                end
            end
            default: begin
                state_s      = ST_IDLE;
                rsp0_valid_s = 1'b0;
                rsp1_valid_s = 1'b0;
                busy_s       = 1'b0;
                instr_s      = CODE_INSTR_NOP;
                op_a_s       = DATA_ZERO;
                op_b_s       = DATA_ZERO;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Arbitration, latched request, captured result and registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;
            count_r      <= 8'd0;
            instr_r      <= CODE_INSTR_NOP;
            op_a_r       <= DATA_ZERO;
            op_b_r       <= DATA_ZERO;
            res_a_r      <= DATA_ZERO;
            res_b_r      <= DATA_ZERO;
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            owner_r      <= owner_s;
            last_grant_r <= last_grant_s;
            count_r      <= count_s;
            instr_r      <= instr_s;
            op_a_r       <= op_a_s;
            op_b_r       <= op_b_s;
            res_a_r      <= res_a_s;
            res_b_r      <= res_b_s;
            rsp0_valid_r <= rsp0_valid_s;
            rsp1_valid_r <= rsp1_valid_s;
            busy_r       <= busy_s;
        end
    end

    assign bus.Req0Ready       = req0_ready_s;
    assign bus.Req1Ready       = req1_ready_s;
    assign bus.Rsp0Valid       = rsp0_valid_r;
    assign bus.Rsp1Valid       = rsp1_valid_r;
    assign bus.Rsp0A           = res_a_r;
    assign bus.Rsp0B           = res_b_r;
    assign bus.Rsp1A           = res_a_r;
    assign bus.Rsp1B           = res_b_r;
    assign bus.CalcInstruction = instr_r;
    assign bus.CalcInputA      = op_a_r;
    assign bus.CalcInputB      = op_b_r;
    assign bus.Busy            = busy_r;

endmodule

// File: tb/tb_mini_calc_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mini_calc_arbiter
// Drives two arbiter instances: the main one (CALC_LATENCY=2) with directed
// and random traffic from both requesters, and a second one (CALC_LATENCY=1)
// with a continuously valid requester 0. A small MiniCalc stand-in supplies
// results; a cycle-level reference model predicts grants, readies, busy,
// calculator drive and response timing, and scoreboard queues hold the
// expected result pairs.
// ---------------------------------------------------------------------------
module tb_mini_calc_arbiter;

    localparam int IW    = 8;
    localparam int NW    = 4;
    localparam int LAT   = 2;
    localparam int LAT_S = 1;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_DIV = 4'hC;
    localparam logic [3:0] OP_MUL = 4'hD;
    localparam logic [3:0] OP_NOP = 4'hF;

    logic Clk = 1'b0;
    logic Reset;
    logic rst_s;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   rand_phase = 1'b0;

    mini_calc_arbiter_if #(.INPUT_BIT_WIDTH(IW), .INSTR_BIT_WIDTH(NW)) bus ();
    mini_calc_arbiter_if #(.INPUT_BIT_WIDTH(IW), .INSTR_BIT_WIDTH(NW)) sbus ();

    mini_calc_arbiter #(.INPUT_BIT_WIDTH(IW), .INSTR_BIT_WIDTH(NW),
                        .CODE_INSTR_NOP(OP_NOP), .CALC_LATENCY(LAT))
        u_dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    mini_calc_arbiter #(.INPUT_BIT_WIDTH(IW), .INSTR_BIT_WIDTH(NW),
                        .CODE_INSTR_NOP(OP_NOP), .CALC_LATENCY(LAT_S))
        u_str (.Clk(Clk), .Reset(rst_s), .bus(sbus));

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // MiniCalc behaviour assumed by this bench: result pair {B,A}.
    function automatic logic [15:0] calc_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] r;
        case (op)
            OP_MUL:  r = 16'(a) * 16'(b);
            OP_DIV:  if (b == 8'd0) r = {a, 8'hFF}; else r = {a % b, a / b};
            OP_ADD:  r = {a - b, a + b};
            OP_NOP:  r = 16'h0000;
            default: r = {~a, a ^ b};
        endcase
        return r;
    endfunction

    // Calculator stand-in for the LAT=2 instance: one register stage, so a
    // result is only right once operands have been stable for two cycles.
    logic [3:0]  d_op;
    logic [7:0]  d_a, d_b;
    logic [15:0] calc_out, scalc_out;
    always @(posedge Clk) begin
        d_op <= bus.CalcInstruction;
        d_a  <= bus.CalcInputA;
        d_b  <= bus.CalcInputB;
    end
    always_comb calc_out  = calc_f(d_op, d_a, d_b);
    always_comb scalc_out = calc_f(sbus.CalcInstruction, sbus.CalcInputA, sbus.CalcInputB);
    assign bus.CalcOutputA  = calc_out[7:0];
    assign bus.CalcOutputB  = calc_out[15:8];
    assign sbus.CalcOutputA = scalc_out[7:0];
    assign sbus.CalcOutputB = scalc_out[15:8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model + scoreboard for the main instance ----
    bit          m_inflight = 1'b0;
    bit          m_owner = 1'b0;
    bit          m_last = 1'b1;
    int          m_age = 0;
    logic [3:0]  m_op;
    logic [7:0]  m_a, m_b;
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    bit          prev_rst = 1'b0;
    bit          hold0 = 1'b0, hold1 = 1'b0;
    logic [15:0] hold_d0, hold_d1;

    always @(negedge Clk) begin : model_mon
        bit          pick, e_r0, e_r1, e_v0, e_v1;
        logic [15:0] got;
        if (Reset) begin
            check("rst_req0_ready", 32'(bus.Req0Ready), 32'd0);
            check("rst_req1_ready", 32'(bus.Req1Ready), 32'd0);
            if (prev_rst) begin
                check("rst_busy", 32'(bus.Busy), 32'd0);
                check("rst_rsp0_valid", 32'(bus.Rsp0Valid), 32'd0);
                check("rst_rsp1_valid", 32'(bus.Rsp1Valid), 32'd0);
                check("rst_calc_instr", 32'(bus.CalcInstruction), 32'(OP_NOP));
                check("rst_calc_a", 32'(bus.CalcInputA), 32'd0);
            end
            m_inflight = 1'b0;
            m_last     = 1'b1;
            m_age      = 0;
            hold0      = 1'b0;
            hold1      = 1'b0;
            q0.delete();
            q1.delete();
            prev_rst   = 1'b1;
        end else begin
            prev_rst = 1'b0;
            if (m_inflight) m_age++;
            if (bus.Req0Valid && bus.Req1Valid) pick = ~m_last;
            else pick = bus.Req1Valid;
            e_r0 = !m_inflight && bus.Req0Valid && !pick;
            e_r1 = !m_inflight && bus.Req1Valid && pick;
            e_v0 = m_inflight && !m_owner && (m_age >= LAT + 1);
            e_v1 = m_inflight &&  m_owner && (m_age >= LAT + 1);
            check("req0_ready", 32'(bus.Req0Ready), 32'(e_r0));
            check("req1_ready", 32'(bus.Req1Ready), 32'(e_r1));
            check("busy", 32'(bus.Busy), 32'(m_inflight));
            check("rsp0_valid", 32'(bus.Rsp0Valid), 32'(e_v0));
            check("rsp1_valid", 32'(bus.Rsp1Valid), 32'(e_v1));
            if (m_inflight) begin
                check("calc_instr", 32'(bus.CalcInstruction), 32'(m_op));
                check("calc_a", 32'(bus.CalcInputA), 32'(m_a));
                check("calc_b", 32'(bus.CalcInputB), 32'(m_b));
            end else begin
                check("idle_calc_instr", 32'(bus.CalcInstruction), 32'(OP_NOP));
                check("idle_calc_ab", 32'({bus.CalcInputB, bus.CalcInputA}), 32'd0);
            end
            if (hold0) check("rsp0_stable", 32'({bus.Rsp0B, bus.Rsp0A}), 32'(hold_d0));
            if (hold1) check("rsp1_stable", 32'({bus.Rsp1B, bus.Rsp1A}), 32'(hold_d1));
            hold0   = bus.Rsp0Valid && !bus.Rsp0Ready;
            hold1   = bus.Rsp1Valid && !bus.Rsp1Ready;
            hold_d0 = {bus.Rsp0B, bus.Rsp0A};
            hold_d1 = {bus.Rsp1B, bus.Rsp1A};
            if (bus.Rsp0Valid && bus.Rsp0Ready) begin
                if (q0.size() == 0) check("rsp0_unexpected", 32'd1, 32'd0);
                else begin
                    got = q0.pop_front();
                    check("rsp0_data", 32'({bus.Rsp0B, bus.Rsp0A}), 32'(got));
                end
            end
            if (bus.Rsp1Valid && bus.Rsp1Ready) begin
                if (q1.size() == 0) check("rsp1_unexpected", 32'd1, 32'd0);
                else begin
                    got = q1.pop_front();
                    check("rsp1_data", 32'({bus.Rsp1B, bus.Rsp1A}), 32'(got));
                end
            end
            if ((e_v0 && bus.Rsp0Ready) || (e_v1 && bus.Rsp1Ready)) m_inflight = 1'b0;
            if (e_r0) begin
                m_op = bus.Req0Instr; m_a = bus.Req0A; m_b = bus.Req0B;
                q0.push_back(calc_f(m_op, m_a, m_b));
            end else if (e_r1) begin
                m_op = bus.Req1Instr; m_a = bus.Req1A; m_b = bus.Req1B;
                q1.push_back(calc_f(m_op, m_a, m_b));
            end
            if (e_r0 || e_r1) begin
                m_owner    = e_r1;
                m_last     = e_r1;
                m_inflight = 1'b1;
                m_age      = 0;
            end
        end
    end

    // ---------------- scoreboard for the streaming instance -----------------
    logic [15:0] qs[$];
    int          s_last_acc = -1;

    always @(negedge Clk) begin : str_mon
        logic [15:0] got;
        if (rst_s) begin
            qs.delete();
            s_last_acc = -1;
        end else begin
            if (sbus.Rsp0Valid && sbus.Rsp0Ready) begin
                if (qs.size() == 0) check("stream_unexpected", 32'd1, 32'd0);
                else begin
                    got = qs.pop_front();
                    check("stream_data", 32'({sbus.Rsp0B, sbus.Rsp0A}), 32'(got));
                end
            end
            if (sbus.Rsp1Valid) check("stream_rsp1_valid", 32'(sbus.Rsp1Valid), 32'd0);
            if (sbus.Req0Valid && sbus.Req0Ready) begin
                qs.push_back(calc_f(sbus.Req0Instr, sbus.Req0A, sbus.Req0B));
                if (s_last_acc >= 0) check("stream_spacing", 32'(cyc - s_last_acc), 32'(LAT_S + 2));
                s_last_acc = cyc;
            end
        end
    end

    // ---------------- stimulus helpers --------------------------------------
    // Called just after a rising edge; returns just after the edge that follows accept.
    task automatic issue(input bit r, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, output int t_acc);
        bit got;
        got   = 1'b0;
        t_acc = -1;
        if (r) begin
            bus.Req1Instr = op; bus.Req1A = a; bus.Req1B = b; bus.Req1Valid = 1'b1;
        end else begin
            bus.Req0Instr = op; bus.Req0A = a; bus.Req0B = b; bus.Req0Valid = 1'b1;
        end
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge Clk);
            if ((r && bus.Req1Ready) || (!r && bus.Req0Ready)) begin
                got   = 1'b1;
                t_acc = cyc;
            end
        end
        if (r) check("req1_accept_wait", 32'(got), 32'd1);
        else   check("req0_accept_wait", 32'(got), 32'd1);
        @(posedge Clk); #1;
        if (r) bus.Req1Valid = 1'b0;
        else   bus.Req0Valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge Clk);
            done = !m_inflight && (q0.size() == 0) && (q1.size() == 0);
        end
        check("drain_idle", 32'(done), 32'd1);
        @(posedge Clk); #1;
    endtask

    task automatic run_rand(input bit r, input int n);
        int         t, gap;
        logic [3:0] op;
        for (int i = 0; i < n; i++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge Clk); #1; end
            case ($urandom_range(0, 4))
                0:       op = OP_ADD;
                1:       op = OP_DIV;
                2:       op = OP_MUL;
                3:       op = OP_XOR;
                default: op = OP_NOP;
            endcase
            issue(r, op, 8'($urandom), 8'($urandom), t);
        end
    endtask

    // Random response backpressure while the random phase runs.
    initial begin
        forever begin
            @(posedge Clk); #1;
            if (rand_phase) begin
                bus.Rsp0Ready = ($urandom_range(0, 3) != 0);
                bus.Rsp1Ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // ---------------- main sequence -----------------------------------------
    initial begin
        int  t0, t1, n;
        bit  got, acc;
        Reset = 1'b1;
        rst_s = 1'b1;
        bus.Req0Valid = 1'b1; bus.Req0Instr = OP_MUL; bus.Req0A = 8'd3; bus.Req0B = 8'd4;
        bus.Req1Valid = 1'b1; bus.Req1Instr = OP_ADD; bus.Req1A = 8'd1; bus.Req1B = 8'd2;
        bus.Rsp0Ready = 1'b1; bus.Rsp1Ready = 1'b1;
        sbus.Req0Valid = 1'b0; sbus.Req0Instr = OP_NOP; sbus.Req0A = 8'd0; sbus.Req0B = 8'd0;
        sbus.Req1Valid = 1'b0; sbus.Req1Instr = OP_NOP; sbus.Req1A = 8'd0; sbus.Req1B = 8'd0;
        sbus.Rsp0Ready = 1'b1; sbus.Rsp1Ready = 1'b1;

        // Reset held with both requesters valid.
        repeat (4) @(posedge Clk);
        #1;
        Reset = 1'b0; rst_s = 1'b0;
        bus.Req0Valid = 1'b0; bus.Req1Valid = 1'b0;
        @(posedge Clk); #1;

        // Contention: requester 0 wins the first tie, then 1, next tie 0 again.
        fork
            issue(1'b0, OP_DIV, 8'd100, 8'd7, t0);
            issue(1'b1, OP_ADD, 8'd5, 8'd3, t1);
        join
        check("tie1_req0_first", 32'(t0 < t1), 32'd1);
        fork
            issue(1'b0, OP_XOR, 8'h12, 8'h34, t0);
            issue(1'b1, OP_MUL, 8'd200, 8'd3, t1);
        join
        check("tie2_req0_first", 32'(t0 < t1), 32'd1);
        wait_idle();

        // Single MUL: response three cycles after accept.
        issue(1'b0, OP_MUL, 8'd12, 8'd11, t0);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge Clk);
            got = bus.Rsp0Valid;
        end
        check("mul_rsp_seen", 32'(got), 32'd1);
        check("mul_latency", 32'(cyc - t0), 32'd3);
        check("mul_rsp0a", 32'(bus.Rsp0A), 32'h84);
        check("mul_rsp0b", 32'(bus.Rsp0B), 32'h00);
        check("mul_rsp1_idle", 32'(bus.Rsp1Valid), 32'd0);
        wait_idle();

        // Backpressure on requester 1 while requester 0 waits.
        bus.Rsp1Ready = 1'b0;
        issue(1'b1, OP_XOR, 8'hA5, 8'h3C, t1);
        fork
            issue(1'b0, OP_ADD, 8'd9, 8'd4, t0);
            begin
                got = 1'b0;
                for (int k = 0; k < 20 && !got; k++) begin
                    @(negedge Clk);
                    got = bus.Rsp1Valid;
                end
                check("stall_rsp_seen", 32'(got), 32'd1);
                for (int k = 0; k < 5; k++) begin
                    @(negedge Clk);
                    check("stall_rsp1_valid", 32'(bus.Rsp1Valid), 32'd1);
                    check("stall_rsp1_data", 32'({bus.Rsp1B, bus.Rsp1A}), 32'h5A99);
                    check("stall_req0_ready", 32'(bus.Req0Ready), 32'd0);
                end
                @(posedge Clk); #1;
                bus.Rsp1Ready = 1'b1;
            end
        join
        check("stall_order", 32'(t1 < t0), 32'd1);
        wait_idle();

        // Reset one cycle after accept: the transaction is dropped.
        issue(1'b0, OP_MUL, 8'd7, 8'd9, t0);
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clk);
            check("no_rsp_after_reset", 32'(bus.Rsp0Valid), 32'd0);
        end
        @(posedge Clk); #1;
        issue(1'b1, OP_ADD, 8'd200, 8'd100, t1);
        wait_idle();

        // Random traffic from both requesters with random response stalls.
        rand_phase = 1'b1;
        fork
            run_rand(1'b0, 40);
            run_rand(1'b1, 40);
        join
        rand_phase = 1'b0;
        bus.Rsp0Ready = 1'b1;
        bus.Rsp1Ready = 1'b1;
        wait_idle();

        // Streaming on the LAT=1 instance: valid held high, new operands after each accept.
        sbus.Req0Instr = OP_MUL; sbus.Req0A = 8'($urandom); sbus.Req0B = 8'($urandom);
        sbus.Req0Valid = 1'b1;
        n = 0;
        for (int k = 0; k < 300 && n < 12; k++) begin
            @(negedge Clk);
            acc = sbus.Req0Valid && sbus.Req0Ready;
            @(posedge Clk); #1;
            if (acc) begin
                n++;
                sbus.Req0Instr = (n % 2 == 0) ? OP_DIV : OP_ADD;
                sbus.Req0A = 8'($urandom);
                sbus.Req0B = 8'($urandom);
            end
        end
        sbus.Req0Valid = 1'b0;
        check("stream_accepts", 32'(n), 32'd12);
        repeat (6) @(posedge Clk);
        #1;
        check("stream_drained", 32'(qs.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
